// File: rtl/ej32_pkg.sv
// ej32_pkg: shared constants and types for the eJ32 front end
package ej32_pkg;
  localparam int FETCH_ASZ = 17;
  localparam logic [7:0] OP_NOP = 8'h00;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} fetch_st_t;
endpackage

// File: rtl/ej32_fetch_q.sv
// ej32_fetch_q: byte FIFO with head and two-deep peek, simultaneous push/pop and sync clear
module ej32_fetch_q import ej32_pkg::*; #(
  parameter int QD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [7:0]            pk1,
  output logic [7:0]            pk2,
  output logic [$clog2(QD):0]   cnt
);
  localparam int AW = $clog2(QD);
  logic [7:0] mem [QD];
  logic [AW:0] wp, rp;
  logic [AW-1:0] r0, r1, r2;
  logic do_push, do_pop;
  assign cnt = wp - rp;
  assign do_pop = pop && cnt != '0;
  assign do_push = push && (!cnt[AW] || do_pop);
  assign r0 = rp[AW-1:0];
  assign r1 = r0 + AW'(1);
  assign r2 = r0 + AW'(2);
  assign head = cnt != '0 ? mem[r0] : OP_NOP;
  assign pk1 = int'(cnt) > 1 ? mem[r1] : 8'h00;
  assign pk2 = int'(cnt) > 2 ? mem[r2] : 8'h00;
  // pointer update; extra MSB tells full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  // byte storage, writing the slot a same-cycle pop frees is safe
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ej32_fetch.sv
// ej32_fetch: bytecode prefetch unit feeding the eJ32 decoder
module ej32_fetch import ej32_pkg::*; #(
  parameter int             ASZ    = FETCH_ASZ,
  parameter int             QD     = 4,
  parameter int             MAXO   = 2,
  parameter logic [ASZ-1:0] RST_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           mem_req,
  output logic [ASZ-1:0] mem_a,
  input  logic           mem_rdy,
  input  logic           mem_vld,
  input  logic [7:0]     mem_d,
  input  logic           redir,
  input  logic [ASZ-1:0] redir_a,
  input  logic           adv,
  output logic [7:0]     code_o,
  output logic [7:0]     op1_o,
  output logic [7:0]     op2_o,
  output logic [2:0]     cnt_o,
  output logic           code_vld,
  output logic [ASZ-1:0] p_o
);
  localparam int QW = $clog2(QD);
  localparam int OW = $clog2(MAXO + 1);
  fetch_st_t st;
  logic [ASZ-1:0] fa, p;
  logic [OW-1:0] outst, drop, outst_n;
  logic [QW:0] qcnt;
  logic run, rd, acc, push, pop;
  assign run = st == S_RUN;
  assign rd = redir && run;
  assign code_vld = qcnt != '0;
  assign mem_req = run && !redir && int'(outst) < MAXO && int'(qcnt) + int'(outst) - int'(drop) < QD;
  assign mem_a = fa;
  assign acc = mem_req && mem_rdy;
  assign outst_n = outst + OW'(acc) - OW'(mem_vld);
  assign push = mem_vld && drop == '0 && !rd;
  assign pop = adv && code_vld && !rd;
  assign cnt_o = int'(qcnt) > 3 ? 3'd3 : 3'(qcnt);
  assign p_o = p;
  ej32_fetch_q #(.QD(QD)) u_q (
    .clk(clk), .rst_n(rst_n), .clr(rd), .push(push), .din(mem_d), .pop(pop),
    .head(code_o), .pk1(op1_o), .pk2(op2_o), .cnt(qcnt)
  );
  // fetch address, head address and in-flight/drop accounting; redirect wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      fa <= '0;
      p <= RST_PC;
      outst <= '0;
      drop <= '0;
    end else if (!run) begin
      st <= S_RUN;
      fa <= RST_PC;
    end else begin
      outst <= outst_n;
      fa <= rd ? redir_a : acc ? fa + ASZ'(1) : fa;
      p <= rd ? redir_a : pop ? p + ASZ'(1) : p;
      drop <= rd ? outst_n : (mem_vld && drop != '0) ? drop - OW'(1) : drop;
    end
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(mem_vld && outst == '0));
endmodule
